sram_phase_scheduler: RTL and testbench

- Top-level sequencer and SRAM owner-select for the image-decode flow.
- Runs the phase sequence IDLE -> UART load -> M2 (IDCT) -> M1 (colourspace/upsample) -> IDLE.
- Drives the enable handshakes to each unit and muxes their SRAM address, write-data and we_n onto the single SRAM controller port.
- Adds a per-phase watchdog so a hung milestone unit cannot lock the SRAM.

---
 rtl/sram_phase_scheduler.sv | 183 ++++++++++++++++++
 tb/tb_sram_phase_scheduler.sv | 422 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_phase_scheduler.sv
// Phase sequencer for the image-decode flow: UART load, IDCT, colourspace.
// Owns the single SRAM port and hands it to whichever unit is active.
module sram_phase_scheduler #(
    parameter logic [25:0] UART_TIMEOUT    = 26'd49999999,
    parameter logic [31:0] WATCHDOG_CYCLES = 32'd0,
    parameter logic        SIM_AUTOSTART   = 1'b0
) (
    input  logic        Clock_50,
    input  logic        Reset,
    input  logic        Start_req,
    input  logic [17:0] UART_SRAM_address,
    input  logic [15:0] UART_SRAM_write_data,
    input  logic        UART_SRAM_we_n,
    input  logic [17:0] M1_SRAM_address,
    input  logic [15:0] M1_SRAM_write_data,
    input  logic        M1_we_n,
    input  logic        m1_disable,
    input  logic [17:0] M2_SRAM_address,
    input  logic [15:0] M2_SRAM_write_data,
    input  logic        M2_we_n,
    input  logic        m2_disable,
    input  logic [17:0] VGA_SRAM_address,
    output logic        UART_rx_initialize,
    output logic        UART_rx_enable,
    output logic        m2_enable,
    output logic        m1_enable,
    output logic        VGA_enable,
    output logic [17:0] SRAM_address,
    output logic [15:0] SRAM_write_data,
    output logic        SRAM_we_n,
    output logic [2:0]  Phase_state,
    output logic        Watchdog_error
);

    typedef enum logic [2:0] {
        S_IDLE           = 3'd0,
        S_ENABLE_UART_RX = 3'd1,
        S_WAIT_UART_RX   = 3'd2,
        S_M2             = 3'd3,
        S_M1             = 3'd4
    } state_e;

    localparam logic        WD_ON   = (WATCHDOG_CYCLES != 32'd0);
    localparam logic [31:0] WD_LAST = WATCHDOG_CYCLES - 32'd1;

    state_e      state_q, state_d;
    logic [25:0] timer_q, timer_d;
    logic [31:0] wd_q, wd_d;
    logic        rx_init_q, rx_init_d;
    logic        rx_en_q, rx_en_d;
    logic        m2_en_q, m2_en_d;
    logic        m1_en_q, m1_en_d;
    logic        vga_en_q, vga_en_d;
    logic        wd_err_q, wd_err_d;
    logic        wd_expire;
    logic        mux_we_n;

    always_ff @(posedge Clock_50) begin
        if (Reset) begin
            state_q   <= S_IDLE;
            timer_q   <= '0;
            wd_q      <= '0;
            rx_init_q <= 1'b0;
            rx_en_q   <= 1'b0;
            m2_en_q   <= 1'b0;
            m1_en_q   <= 1'b0;
            vga_en_q  <= 1'b0;
            wd_err_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            timer_q   <= timer_d;
            wd_q      <= wd_d;
            rx_init_q <= rx_init_d;
            rx_en_q   <= rx_en_d;
            m2_en_q   <= m2_en_d;
            m1_en_q   <= m1_en_d;
            vga_en_q  <= vga_en_d;
            wd_err_q  <= wd_err_d;
        end
    end

    // Expiry fires on the WATCHDOG_CYCLES-th cycle spent in a milestone state.
    assign wd_expire = WD_ON && (wd_q == WD_LAST);

    always_comb begin
        state_d   = state_q;
        rx_init_d = 1'b0;
        rx_en_d   = 1'b0;
        m2_en_d   = m2_en_q;
        m1_en_d   = m1_en_q;
        vga_en_d  = vga_en_q;
        wd_err_d  = wd_err_q;
        wd_d      = '0;
        timer_d   = (rx_init_q || !UART_SRAM_we_n) ? '0 : timer_q + 26'd1;

        case (state_q)
            S_IDLE: begin
                vga_en_d = 1'b1;
                m1_en_d  = 1'b0;
                m2_en_d  = 1'b0;
                if (Start_req) begin
                    rx_init_d = 1'b1;
                    vga_en_d  = 1'b0;
                    state_d   = S_ENABLE_UART_RX;
                end else if (SIM_AUTOSTART && timer_q == 26'd9) begin
                    m2_en_d = 1'b1;
                    state_d = S_M2;
                end
            end
            S_ENABLE_UART_RX: begin
                rx_en_d = 1'b1;
                state_d = S_WAIT_UART_RX;
            end
            S_WAIT_UART_RX: begin
                if (timer_q == UART_TIMEOUT && UART_SRAM_address != 18'd0) begin
                    rx_init_d = 1'b1;
                    m2_en_d   = 1'b1;
                    state_d   = S_M2;
                end
            end
            S_M2: begin
                wd_d = wd_q + 32'd1;
                if (m2_disable) begin
                    m2_en_d = 1'b0;
                    m1_en_d = 1'b1;
                    wd_d    = '0;
                    state_d = S_M1;
                end else if (wd_expire) begin
                    m2_en_d  = 1'b0;
                    wd_err_d = 1'b1;
                    state_d  = S_IDLE;
                end
            end
            S_M1: begin
                wd_d = wd_q + 32'd1;
                if (m1_disable) begin
                    m1_en_d  = 1'b0;
                    vga_en_d = 1'b1;
                    state_d  = S_IDLE;
                end else if (wd_expire) begin
                    m1_en_d  = 1'b0;
                    wd_err_d = 1'b1;
                    state_d  = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        SRAM_address    = VGA_SRAM_address;
        SRAM_write_data = UART_SRAM_write_data;
        mux_we_n        = 1'b1;
        case (state_q)
            S_ENABLE_UART_RX, S_WAIT_UART_RX: begin
                SRAM_address = UART_SRAM_address;
                mux_we_n     = UART_SRAM_we_n;
            end
            S_M2: begin
                SRAM_address    = M2_SRAM_address;
                SRAM_write_data = M2_SRAM_write_data;
                mux_we_n        = M2_we_n;
            end
            S_M1: begin
                SRAM_address    = M1_SRAM_address;
                SRAM_write_data = M1_SRAM_write_data;
                mux_we_n        = M1_we_n;
            end
            default: ;
        endcase
    end

    // Reset must block writes immediately, before the state register catches up.
    assign SRAM_we_n          = Reset | mux_we_n;
    assign UART_rx_initialize = rx_init_q;
    assign UART_rx_enable     = rx_en_q;
    assign m2_enable          = m2_en_q;
    assign m1_enable          = m1_en_q;
    assign VGA_enable         = vga_en_q;
    assign Phase_state        = state_q;
    assign Watchdog_error     = wd_err_q;

endmodule

// File: tb/tb_sram_phase_scheduler.sv
// Randomized bench for sram_phase_scheduler with a phase-level reference
// model (UART idle counter, milestone dwell counts, SRAM ownership table).
module tb_sram_phase_scheduler;

    localparam int TIMEOUT = 100;
    localparam int WD      = 50;

    logic        Clock_50;
    logic        Reset;
    logic        Start_req;
    logic [17:0] UART_SRAM_address;
    logic [15:0] UART_SRAM_write_data;
    logic        UART_SRAM_we_n;
    logic [17:0] M1_SRAM_address;
    logic [15:0] M1_SRAM_write_data;
    logic        M1_we_n;
    logic        m1_disable;
    logic [17:0] M2_SRAM_address;
    logic [15:0] M2_SRAM_write_data;
    logic        M2_we_n;
    logic        m2_disable;
    logic [17:0] VGA_SRAM_address;
    logic        UART_rx_initialize;
    logic        UART_rx_enable;
    logic        m2_enable;
    logic        m1_enable;
    logic        VGA_enable;
    logic [17:0] SRAM_address;
    logic [15:0] SRAM_write_data;
    logic        SRAM_we_n;
    logic [2:0]  Phase_state;
    logic        Watchdog_error;

    int n_checks = 0;
    int n_pass   = 0;

    sram_phase_scheduler #(
        .UART_TIMEOUT    (26'd100),
        .WATCHDOG_CYCLES (32'd50),
        .SIM_AUTOSTART   (1'b0)
    ) dut (
        .Clock_50             (Clock_50),
        .Reset                (Reset),
        .Start_req            (Start_req),
        .UART_SRAM_address    (UART_SRAM_address),
        .UART_SRAM_write_data (UART_SRAM_write_data),
        .UART_SRAM_we_n       (UART_SRAM_we_n),
        .M1_SRAM_address      (M1_SRAM_address),
        .M1_SRAM_write_data   (M1_SRAM_write_data),
        .M1_we_n              (M1_we_n),
        .m1_disable           (m1_disable),
        .M2_SRAM_address      (M2_SRAM_address),
        .M2_SRAM_write_data   (M2_SRAM_write_data),
        .M2_we_n              (M2_we_n),
        .m2_disable           (m2_disable),
        .VGA_SRAM_address     (VGA_SRAM_address),
        .UART_rx_initialize   (UART_rx_initialize),
        .UART_rx_enable       (UART_rx_enable),
        .m2_enable            (m2_enable),
        .m1_enable            (m1_enable),
        .VGA_enable           (VGA_enable),
        .SRAM_address         (SRAM_address),
        .SRAM_write_data      (SRAM_write_data),
        .SRAM_we_n            (SRAM_we_n),
        .Phase_state          (Phase_state),
        .Watchdog_error       (Watchdog_error)
    );

    initial Clock_50 = 1'b0;
    always #5 Clock_50 = ~Clock_50;

    task automatic tick();
        @(posedge Clock_50);
        #1;
    endtask

    // Which unit owns the SRAM port in a given phase (0 idle .. 4 M1).
    function automatic logic [34:0] model_sram(input int ph);
        case (ph)
            1, 2: return {UART_SRAM_address, UART_SRAM_write_data, UART_SRAM_we_n};
            3: return {M2_SRAM_address, M2_SRAM_write_data, M2_we_n};
            4: return {M1_SRAM_address, M1_SRAM_write_data, M1_we_n};
            default: return {VGA_SRAM_address, UART_SRAM_write_data, 1'b1};
        endcase
    endfunction

    task automatic scramble_buses();
        M1_SRAM_address      = 18'($urandom);
        M1_SRAM_write_data   = 16'($urandom);
        M1_we_n              = 1'($urandom);
        M2_SRAM_address      = 18'($urandom);
        M2_SRAM_write_data   = 16'($urandom);
        M2_we_n              = 1'($urandom);
        VGA_SRAM_address     = 18'($urandom);
        UART_SRAM_write_data = 16'($urandom);
    endtask

    task automatic enter_m2();
        UART_SRAM_address = 18'h00040;
        UART_SRAM_we_n    = 1'b1;
        Start_req         = 1'b1;
        tick();
        Start_req = 1'b0;
        repeat (TIMEOUT + 2) tick();
    endtask

    task automatic test_reset();
        Reset = 1'b1;
        M1_we_n = 1'b0;
        repeat (3) tick();
        @(negedge Clock_50);
        n_checks++;
        if ({Phase_state, VGA_enable, m1_enable, m2_enable, SRAM_we_n} !== {3'd0, 4'b0001})
            $display("FAIL reset_state: got %b want 0000001",
                     {Phase_state, VGA_enable, m1_enable, m2_enable, SRAM_we_n});
        else n_pass++;
        n_checks++;
        if ({UART_rx_initialize, UART_rx_enable, Watchdog_error} !== 3'b000)
            $display("FAIL reset_pulses: got %b want 000",
                     {UART_rx_initialize, UART_rx_enable, Watchdog_error});
        else n_pass++;
        tick();
        Reset = 1'b0;
        m2_disable = 1'b1;
        m1_disable = 1'b1;
        tick();
        m2_disable = 1'b0;
        m1_disable = 1'b0;
        scramble_buses();
        tick();
        @(negedge Clock_50);
        n_checks++;
        if ({Phase_state, VGA_enable} !== {3'd0, 1'b1})
            $display("FAIL idle_state: got %b want 0001", {Phase_state, VGA_enable});
        else n_pass++;
        n_checks++;
        if ({SRAM_address, SRAM_write_data, SRAM_we_n} !== model_sram(0))
            $display("FAIL idle_mux: got %h want %h",
                     {SRAM_address, SRAM_write_data, SRAM_we_n}, model_sram(0));
        else n_pass++;
    endtask

    task automatic test_uart_load(input bit with_writes);
        int timer, cycles, last_wr, exp_cycles;
        bit go;
        timer   = 0;
        cycles  = 0;
        last_wr = -1;
        go      = 1'b0;
        UART_SRAM_address = 18'h00040;
        UART_SRAM_we_n    = 1'b1;
        Start_req = 1'b1;
        tick();
        Start_req = 1'b0;
        @(negedge Clock_50);
        n_checks++;
        if ({Phase_state, UART_rx_initialize, UART_rx_enable, VGA_enable} !== {3'd1, 3'b100})
            $display("FAIL uart_init_pulse: got %b want 001100",
                     {Phase_state, UART_rx_initialize, UART_rx_enable, VGA_enable});
        else n_pass++;
        tick();
        while (!go && cycles < 400) begin
            UART_SRAM_we_n = 1'b1;
            if (with_writes && cycles < 20 && $urandom_range(3) == 0) begin
                UART_SRAM_we_n = 1'b0;
                last_wr = cycles;
            end
            UART_SRAM_write_data = 16'($urandom);
            VGA_SRAM_address     = 18'($urandom);
            @(negedge Clock_50);
            if (cycles == 0) begin
                n_checks++;
                if ({UART_rx_initialize, UART_rx_enable} !== 2'b01)
                    $display("FAIL uart_enable_pulse: got %b want 01",
                             {UART_rx_initialize, UART_rx_enable});
                else n_pass++;
            end
            if (cycles % 17 == 0 || UART_SRAM_we_n == 1'b0) begin
                n_checks++;
                if (Phase_state !== 3'd2)
                    $display("FAIL uart_wait_state: got %0d want 2 at cycle %0d",
                             Phase_state, cycles);
                else n_pass++;
                n_checks++;
                if ({SRAM_address, SRAM_write_data, SRAM_we_n} !== model_sram(2))
                    $display("FAIL uart_mux: got %h want %h",
                             {SRAM_address, SRAM_write_data, SRAM_we_n}, model_sram(2));
                else n_pass++;
            end
            go = (timer == TIMEOUT);
            timer = (UART_SRAM_we_n == 1'b0) ? 0 : timer + 1;
            cycles++;
            tick();
        end
        UART_SRAM_we_n = 1'b1;
        exp_cycles = (last_wr < 0) ? TIMEOUT + 1 : last_wr + TIMEOUT + 2;
        n_checks++;
        if (cycles !== exp_cycles)
            $display("FAIL uart_wait_length: got %0d want %0d", cycles, exp_cycles);
        else n_pass++;
        @(negedge Clock_50);
        n_checks++;
        if ({Phase_state, m2_enable, m1_enable, UART_rx_initialize} !== {3'd3, 3'b101})
            $display("FAIL m2_entry: got %b want 011101",
                     {Phase_state, m2_enable, m1_enable, UART_rx_initialize});
        else n_pass++;
    endtask

    task automatic test_m2_to_m1();
        int d;
        d = $urandom_range(1, 40);
        for (int i = 1; i <= d; i++) begin
            scramble_buses();
            Start_req  = 1'($urandom);
            m1_disable = 1'($urandom);
            m2_disable = (i == d);
            @(negedge Clock_50);
            n_checks++;
            if ({Phase_state, m2_enable} !== {3'd3, 1'b1})
                $display("FAIL m2_hold: got %b want 0111 at cycle %0d",
                         {Phase_state, m2_enable}, i);
            else n_pass++;
            n_checks++;
            if ({SRAM_address, SRAM_write_data, SRAM_we_n} !== model_sram(3))
                $display("FAIL m2_mux: got %h want %h",
                         {SRAM_address, SRAM_write_data, SRAM_we_n}, model_sram(3));
            else n_pass++;
            tick();
        end
        Start_req  = 1'b0;
        m1_disable = 1'b0;
        m2_disable = 1'b0;
        M1_SRAM_address = 18'h23C00;
        @(negedge Clock_50);
        n_checks++;
        if ({Phase_state, m2_enable, m1_enable, VGA_enable, Watchdog_error} !== {3'd4, 4'b0100})
            $display("FAIL m1_entry: got %b want 1000100",
                     {Phase_state, m2_enable, m1_enable, VGA_enable, Watchdog_error});
        else n_pass++;
        n_checks++;
        if (SRAM_address !== 18'h23C00)
            $display("FAIL m1_addr: got %h want 23c00", SRAM_address);
        else n_pass++;
    endtask

    task automatic test_m1_done();
        int d;
        d = $urandom_range(1, 30);
        for (int i = 1; i <= d; i++) begin
            scramble_buses();
            M1_we_n            = 1'b0;
            M1_SRAM_write_data = 16'hBEEF;
            m2_disable         = 1'($urandom);
            m1_disable         = (i == d);
            @(negedge Clock_50);
            n_checks++;
            if ({SRAM_address, SRAM_write_data, SRAM_we_n} !== model_sram(4))
                $display("FAIL m1_mux: got %h want %h",
                         {SRAM_address, SRAM_write_data, SRAM_we_n}, model_sram(4));
            else n_pass++;
            tick();
        end
        m1_disable = 1'b0;
        m2_disable = 1'b0;
        @(negedge Clock_50);
        n_checks++;
        if ({Phase_state, VGA_enable, m1_enable, SRAM_we_n} !== {3'd0, 3'b101})
            $display("FAIL m1_exit: got %b want 000101",
                     {Phase_state, VGA_enable, m1_enable, SRAM_we_n});
        else n_pass++;
        n_checks++;
        if (SRAM_address !== VGA_SRAM_address)
            $display("FAIL m1_exit_addr: got %h want %h", SRAM_address, VGA_SRAM_address);
        else n_pass++;
        M1_we_n = 1'b1;
    endtask

    task automatic test_done_at_expiry();
        enter_m2();
        for (int i = 1; i <= WD; i++) begin
            m2_disable = (i == WD);
            @(negedge Clock_50);
            if (i == WD) begin
                n_checks++;
                if (Phase_state !== 3'd3)
                    $display("FAIL expiry_race_hold: got %0d want 3", Phase_state);
                else n_pass++;
            end
            tick();
        end
        m2_disable = 1'b0;
        @(negedge Clock_50);
        n_checks++;
        if ({Phase_state, m1_enable, Watchdog_error} !== {3'd4, 2'b10})
            $display("FAIL expiry_race: got %b want 10010",
                     {Phase_state, m1_enable, Watchdog_error});
        else n_pass++;
        m1_disable = 1'b1;
        tick();
        m1_disable = 1'b0;
    endtask

    task automatic test_watchdog();
        enter_m2();
        for (int i = 1; i <= WD; i++) begin
            @(negedge Clock_50);
            if (i == 1 || i == WD) begin
                n_checks++;
                if ({Phase_state, Watchdog_error} !== {3'd3, 1'b0})
                    $display("FAIL wd_m2_hold: got %b want 0110 at cycle %0d",
                             {Phase_state, Watchdog_error}, i);
                else n_pass++;
            end
            tick();
        end
        @(negedge Clock_50);
        n_checks++;
        if ({Phase_state, m2_enable, Watchdog_error} !== {3'd0, 2'b01})
            $display("FAIL wd_m2_expire: got %b want 00001",
                     {Phase_state, m2_enable, Watchdog_error});
        else n_pass++;
        repeat (5) tick();
        enter_m2();
        @(negedge Clock_50);
        n_checks++;
        if ({Phase_state, Watchdog_error} !== {3'd3, 1'b1})
            $display("FAIL wd_sticky: got %b want 0111", {Phase_state, Watchdog_error});
        else n_pass++;
        m2_disable = 1'b1;
        tick();
        m2_disable = 1'b0;
        for (int i = 1; i <= WD; i++) begin
            @(negedge Clock_50);
            if (i == WD) begin
                n_checks++;
                if (Phase_state !== 3'd4)
                    $display("FAIL wd_m1_hold: got %0d want 4", Phase_state);
                else n_pass++;
            end
            tick();
        end
        @(negedge Clock_50);
        n_checks++;
        if ({Phase_state, m1_enable, Watchdog_error} !== {3'd0, 2'b01})
            $display("FAIL wd_m1_expire: got %b want 00001",
                     {Phase_state, m1_enable, Watchdog_error});
        else n_pass++;
    endtask

    task automatic test_reset_mid_phase();
        enter_m2();
        m2_disable = 1'b1;
        tick();
        m2_disable = 1'b0;
        M1_we_n = 1'b0;
        Reset   = 1'b1;
        @(negedge Clock_50);
        n_checks++;
        if ({Phase_state, SRAM_we_n} !== {3'd4, 1'b1})
            $display("FAIL reset_we_comb: got %b want 1001", {Phase_state, SRAM_we_n});
        else n_pass++;
        tick();
        @(negedge Clock_50);
        n_checks++;
        if ({Phase_state, m1_enable, m2_enable, VGA_enable, Watchdog_error} !== 7'b0)
            $display("FAIL reset_mid_phase: got %b want 0000000",
                     {Phase_state, m1_enable, m2_enable, VGA_enable, Watchdog_error});
        else n_pass++;
        Reset   = 1'b0;
        M1_we_n = 1'b1;
        tick();
    endtask

    task automatic test_uart_zero_addr();
        UART_SRAM_address = 18'd0;
        UART_SRAM_we_n    = 1'b1;
        Start_req = 1'b1;
        tick();
        Start_req = 1'b0;
        repeat (TIMEOUT + 31) tick();
        @(negedge Clock_50);
        n_checks++;
        if ({Phase_state, m2_enable} !== {3'd2, 1'b0})
            $display("FAIL uart_zero_addr: got %b want 0100", {Phase_state, m2_enable});
        else n_pass++;
        Reset = 1'b1;
        tick();
        Reset = 1'b0;
        tick();
    endtask

    initial begin
        Reset = 1'b1;
        Start_req = 1'b0;
        UART_SRAM_address = 18'h00040;
        UART_SRAM_write_data = 16'h0;
        UART_SRAM_we_n = 1'b1;
        M1_SRAM_address = 18'h0;
        M1_SRAM_write_data = 16'h0;
        M1_we_n = 1'b1;
        m1_disable = 1'b0;
        M2_SRAM_address = 18'h0;
        M2_SRAM_write_data = 16'h0;
        M2_we_n = 1'b1;
        m2_disable = 1'b0;
        VGA_SRAM_address = 18'h12345;
        test_reset();
        test_uart_load(1'b0);
        test_m2_to_m1();
        test_m1_done();
        test_uart_load(1'b1);
        test_m2_to_m1();
        test_m1_done();
        test_done_at_expiry();
        test_watchdog();
        test_reset_mid_phase();
        test_uart_zero_addr();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
